// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR sample sequencer.
package fir_seq_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    localparam logic SRC_1 = 1'b0;
    localparam logic SRC_2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        OUT
    } fir_seq_state_t;

endpackage

// File: rtl/fir_sample_sequencer_arb.sv
// Two-request round-robin arbiter; the pointer names the preferred source on a tie
// and moves to the other source after every grant.
module rr_arb2
    import fir_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic r_ptr;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (r_ptr == SRC_2) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SRC_1;
        end else if (|gnt) begin
            r_ptr <= gnt[0] ? SRC_2 : SRC_1;
        end
    end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Feeds samples from two sources into a shared FIR one at a time, waits the FIR
// pipeline latency, and returns the source-tagged result over valid/ready.
module fir_sample_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned FIR_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    input  logic              s2_valid,
    input  logic [DATA_W-1:0] s2_data,
    output logic              s2_ready,
    output logic              fir_pe_bar,
    output logic [DATA_W-1:0] fir_din,
    input  logic [DATA_W-1:0] fir_dout,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_src,
    input  logic              res_ready,
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = 4'(FIR_LAT - 1);

    fir_seq_state_t    r_state;
    fir_seq_state_t    w_state_next;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_fir_din;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_src;
    logic              r_pe_bar;
    logic              r_res_valid;
    logic              r_busy;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_capture;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({s2_valid, s1_valid}),
        .en    (r_state == IDLE),
        .gnt   (w_gnt)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_accept     = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD: w_state_next = WAIT;
            WAIT: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Strobe/valid/busy are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_fir_din   <= '0;
            r_res_data  <= '0;
            r_res_src   <= SRC_1;
            r_pe_bar    <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pe_bar    <= (w_state_next != LOAD);
            r_res_valid <= (w_state_next == OUT);
            r_busy      <= (w_state_next != IDLE);
            if (w_accept) begin
                r_fir_din <= w_gnt[1] ? s2_data : s1_data;
                r_res_src <= w_gnt[1] ? SRC_2 : SRC_1;
            end
            if (r_state == LOAD) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_res_data <= fir_dout;
            end
        end
    end

    assign s1_ready   = w_gnt[0];
    assign s2_ready   = w_gnt[1];
    assign fir_pe_bar = r_pe_bar;
    assign fir_din    = r_fir_din;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_src    = r_res_src;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: FIR_LAT=4 and FIR_LAT=1 instances share stimulus,
// each checked every cycle against a transaction-level model plus directed literals.
module tb_fir_sample_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s1v = 1'b0, s2v = 1'b0, rr = 1'b0;
    logic [7:0] s1d = 8'd0, s2d = 8'd0;

    logic       s1r [2];
    logic       s2r [2];
    logic       pe [2];
    logic       rv [2];
    logic       rsrc [2];
    logic       busy [2];
    logic [7:0] din [2];
    logic [7:0] dout [2];
    logic [7:0] rdat [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    bit         m_act [2];
    int         m_age [2];
    bit         m_src [2];
    logic [7:0] m_dat [2];
    bit         m_ptr [2];
    logic [7:0] m_ldin [2];
    logic [7:0] m_lres [2];
    bit         m_lsrc [2];

    int acc_c[$];
    bit acc_s[$];

    always #5 clk = ~clk;

    fir_sample_sequencer #(.DATA_W(8), .FIR_LAT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s1_valid(s1v), .s1_data(s1d), .s1_ready(s1r[0]),
        .s2_valid(s2v), .s2_data(s2d), .s2_ready(s2r[0]),
        .fir_pe_bar(pe[0]), .fir_din(din[0]), .fir_dout(dout[0]),
        .res_valid(rv[0]), .res_data(rdat[0]), .res_src(rsrc[0]),
        .res_ready(rr), .busy(busy[0])
    );

    fir_sample_sequencer #(.DATA_W(8), .FIR_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .s1_valid(s1v), .s1_data(s1d), .s1_ready(s1r[1]),
        .s2_valid(s2v), .s2_data(s2d), .s2_ready(s2r[1]),
        .fir_pe_bar(pe[1]), .fir_din(din[1]), .fir_dout(dout[1]),
        .res_valid(rv[1]), .res_data(rdat[1]), .res_src(rsrc[1]),
        .res_ready(rr), .busy(busy[1])
    );

    // Stub FIRs: din+1 appears exactly FIR_LAT edges after the load strobe, junk otherwise.
    logic [7:0] pa [4];
    logic [7:0] pb;
    always @(posedge clk) begin
        pa[0] <= pe[0] ? 8'hEE : din[0] + 8'd1;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
        pb    <= pe[1] ? 8'hEE : din[1] + 8'd1;
    end
    assign dout[0] = pa[3];
    assign dout[1] = pb;

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check(input int k);
        logic       e_s1r, e_s2r, e_pe, e_rv, e_rs, e_busy;
        logic [7:0] e_din, e_rd;
        bit         g1, g2;
        string      p;
        p = (k == 0) ? "L4" : "L1";
        if (!rst_n) begin
            m_act[k]  = 1'b0;
            m_ptr[k]  = 1'b0;
            m_ldin[k] = 8'd0;
            m_lres[k] = 8'd0;
            m_lsrc[k] = 1'b0;
        end
        g1 = 1'b0;
        g2 = 1'b0;
        if (!m_act[k]) begin
            g1 = s1v && (!s2v || !m_ptr[k]);
            g2 = s2v && (!s1v || m_ptr[k]);
            e_s1r = g1; e_s2r = g2; e_pe = 1'b1; e_rv = 1'b0; e_busy = 1'b0;
            e_din = m_ldin[k]; e_rd = m_lres[k]; e_rs = m_lsrc[k];
        end else begin
            e_s1r = 1'b0; e_s2r = 1'b0; e_busy = 1'b1;
            e_pe  = (m_age[k] != 1);
            e_rv  = (m_age[k] >= lat_of(k) + 2);
            e_din = m_dat[k];
            e_rs  = m_src[k];
            e_rd  = e_rv ? m_dat[k] + 8'd1 : m_lres[k];
        end
        chk({p, ".s1_ready"}, 32'(s1r[k]), 32'(e_s1r));
        chk({p, ".s2_ready"}, 32'(s2r[k]), 32'(e_s2r));
        chk({p, ".fir_pe_bar"}, 32'(pe[k]), 32'(e_pe));
        chk({p, ".fir_din"}, 32'(din[k]), 32'(e_din));
        chk({p, ".res_valid"}, 32'(rv[k]), 32'(e_rv));
        chk({p, ".res_data"}, 32'(rdat[k]), 32'(e_rd));
        chk({p, ".res_src"}, 32'(rsrc[k]), 32'(e_rs));
        chk({p, ".busy"}, 32'(busy[k]), 32'(e_busy));
        if (rst_n) begin
            if (!m_act[k]) begin
                if (g1 || g2) begin
                    m_act[k]  = 1'b1;
                    m_age[k]  = 1;
                    m_src[k]  = g2;
                    m_dat[k]  = g2 ? s2d : s1d;
                    m_ptr[k]  = g1;
                    m_ldin[k] = m_dat[k];
                    m_lsrc[k] = g2;
                end
            end else if (e_rv && rr) begin
                m_act[k]  = 1'b0;
                m_lres[k] = e_rd;
            end else begin
                m_age[k]++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        model_check(0);
        model_check(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s1v = 1'b0;
        s2v = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int f0, f1, lows, w;
        logic [7:0] d0, d1;
        logic s0;

        rr = 1'b1;
        step();
        step();
        chk("reset.pe_bar", 32'(pe[0]), 32'd1);
        chk("reset.busy", 32'(busy[0]), 32'd0);
        rst_n = 1'b1;

        // single source
        s1v = 1'b1; s1d = 8'd77;
        step();
        s1v = 1'b0;
        f0 = -1; f1 = -1; d0 = 8'd0; d1 = 8'd0; s0 = 1'b1; lows = 0;
        for (int n = 1; n <= 10; n++) begin
            if (!pe[0]) lows++;
            if (n == 1) chk("t1.fir_din", 32'(din[0]), 32'd77);
            if (rv[0] && f0 < 0) begin f0 = n; d0 = rdat[0]; s0 = rsrc[0]; end
            if (rv[1] && f1 < 0) begin f1 = n; d1 = rdat[1]; end
            step();
        end
        chk("t1.pe_low_cycles", 32'(lows), 32'd1);
        chk("t1.latency_lat4", 32'(f0), 32'd6);
        chk("t1.res_data", 32'(d0), 32'd78);
        chk("t1.res_src", 32'(s0), 32'd0);
        chk("t1.latency_lat1", 32'(f1), 32'd3);
        chk("t1.res_data_lat1", 32'(d1), 32'd78);

        // contention
        do_reset();
        s1v = 1'b1; s2v = 1'b1; s1d = 8'd77; s2d = 8'd66;
        for (int n = 0; n < 40; n++) begin
            if (!pe[0]) begin acc_c.push_back(n); acc_s.push_back(rsrc[0]); end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t2.grant_src", (i < acc_s.size()) ? 32'(acc_s[i]) : 32'd2, 32'(i % 2));
            if (i > 0)
                chk("t2.accept_spacing", (i < acc_c.size()) ? 32'(acc_c[i] - acc_c[i-1]) : 32'd0, 32'd7);
        end
        s1v = 1'b0; s2v = 1'b0;

        // backpressure
        do_reset();
        rr = 1'b0;
        s1v = 1'b1; s1d = 8'd66;
        step();
        s1v = 1'b0;
        w = 0;
        while (!rv[0] && w < 20) begin step(); w++; end
        chk("t3.res_valid_seen", 32'(rv[0]), 32'd1);
        s1v = 1'b1; s2v = 1'b1;
        for (int n = 0; n < 10; n++) begin
            chk("t3.res_valid_hold", 32'(rv[0]), 32'd1);
            chk("t3.res_data_hold", 32'(rdat[0]), 32'd67);
            chk("t3.res_src_hold", 32'(rsrc[0]), 32'd0);
            step();
        end
        rr = 1'b1; s1v = 1'b0; s2v = 1'b0;
        step();
        step();

        // reset during WAIT
        do_reset();
        s1v = 1'b1; s1d = 8'd10;
        step();
        s1v = 1'b0;
        step();
        step();
        chk("t4.busy_before", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4.async_busy", 32'(busy[0]), 32'd0);
        chk("t4.async_pe_bar", 32'(pe[0]), 32'd1);
        chk("t4.async_fir_din", 32'(din[0]), 32'd0);
        chk("t4.async_res_valid", 32'(rv[0]), 32'd0);
        chk("t4.async_res_data_lat1", 32'(rdat[1]), 32'd0);
        chk("t4.async_fir_din_lat1", 32'(din[1]), 32'd0);
        step();
        rst_n = 1'b1;
        s1v = 1'b1; s2v = 1'b1; s1d = 8'd1; s2d = 8'd2;
        step();
        chk("t4.first_grant_src", 32'(rsrc[0]), 32'd0);
        chk("t4.first_grant_din", 32'(din[0]), 32'd1);

        // late request from s2 while s1 is in flight
        s1v = 1'b0; s2v = 1'b0;
        step();
        s2v = 1'b1; s2d = 8'd50; s1v = 1'b1; s1d = 8'd51;
        w = 0;
        while (pe[0] && w < 20) begin step(); w++; end
        chk("t5.load_delay", 32'(w), 32'd6);
        chk("t5.grant_src", 32'(rsrc[0]), 32'd1);
        chk("t5.grant_din", 32'(din[0]), 32'd50);
        s1v = 1'b0; s2v = 1'b0;
        for (int n = 0; n < 10; n++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
